xor_unit_arbiter: RTL and testbench
===================================

Name: xor_unit_arbiter

Overview:
- Round-robin arbiter that shares one pipelined XOR datapath (W-bit, fixed 2-cycle start-to-valid latency) between N requesters.
- Registers the selected operands onto the datapath start/a/b inputs.
- Tracks each issued operation with a tag pipeline and routes the datapath result back to the requester that issued it.
- Sits between the client blocks and the single XOR datapath instance.

Parameters:
W, 16, operand/result width (must match the datapath)
N, 4, number of requesters (2..8)
LAT, 2, datapath latency in cycles from dp_start to dp_valid

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  arbitration enable; low blocks new grants, in-flight ops still complete
req  in  N  per-requester request level
a_in  in  N*W  packed operand A, requester i at bits [i*W +: W]
b_in  in  N*W  packed operand B, same packing
gnt  out  N  one-hot grant pulse, registered
dp_start  out  1  to datapath start, registered
dp_a  out  W  to datapath a, registered
dp_b  out  W  to datapath b, registered
dp_y  in  W  datapath result
dp_valid  in  1  datapath result valid
rsp_valid  out  N  one-hot response pulse
rsp_y  out  W  result, registered, valid with rsp_valid
busy  out  1  any op issued or in flight
err  out  1  sticky protocol error (feature-dependent)

Behaviour:
- Reset (async, rst_n low): gnt=0, dp_start=0, dp_a=0, dp_b=0, rsp_valid=0, rsp_y=0, err=0, busy=0. RR pointer=0, tag pipeline cleared, outstanding mask cleared.
- Reset asserted mid-operation discards all in-flight ops; no response is produced for them.
- Eligibility: req[i] & ~outstanding[i] & en. At most one op per requester in flight.
- Arbitration, per cycle with any eligible requester:
  - Winner is the first eligible index at or after ptr, modulo N.
  - Next edge: gnt[winner]=1, dp_start=1, dp_a/dp_b = requester's a_in/b_in slice, outstanding[winner] set, ptr = winner+1 mod N (wraps N-1 -> 0).
  - No eligible requester: dp_start=0, gnt=0, ptr holds. dp_a/dp_b hold their last values.
- Throughput: one issue per cycle. Back-to-back grants to different requesters are allowed.
- Requester handshake: hold req and operands stable until gnt is seen; drop req or present a new op afterwards. The outstanding mask prevents re-grant on a held req.
- Tag pipeline: LAT+1 stages of {valid, id}. Stage 0 is loaded alongside dp_start, so the expected dp_valid arrives LAT cycles after dp_start is high.
- Response: when the final tag stage is valid and dp_valid=1, the next edge sets rsp_valid[id]=1 and rsp_y=dp_y, and clears outstanding[id] in the same edge.
  - That requester is eligible again the following cycle.
  - Request-to-rsp_valid latency = 1 + LAT + 1 = 4 cycles at default LAT.
- Simultaneous events: a response clear and a new issue for the same id in the same cycle cannot occur, because id is ineligible until the clear has landed. Clears and issues for different ids are independent.
- en deasserted: no new gnt or dp_start. Tag pipeline drains normally.
- busy = dp_start | any tag stage valid | any outstanding bit.
- rsp_valid and gnt are single-cycle pulses.

Optional Feature:
XARB_WDOG_EN
- Defined: err sets and stays set until reset on either mismatch:
  - dp_valid=1 while the final tag stage is invalid (spurious result), or
  - final tag stage valid while dp_valid=0 (missing result).
  - On a missing result: outstanding[id] is still cleared and rsp_valid[id] pulses with rsp_y=0, so the requester is never hung.
- Not defined: err is tied to 0. Responses are produced only when the final tag stage and dp_valid are both valid; a mismatching dp_valid is ignored.

Test Plan:
1. Single request: req=4'b0100, a_in slice 2 = 16'h00FF, b_in slice 2 = 16'h0F0F -> gnt=4'b0100 after 1 cycle; rsp_valid=4'b0100 with rsp_y=16'h0FF0 exactly 4 cycles after req sampled; busy low afterwards.
2. All four requesters held high from reset release, ptr=0 -> grants 0,1,2,3 on consecutive cycles; responses 0..3 on consecutive cycles; no requester granted twice before its response.
3. Wrap: ptr=3 (after granting 2), req=4'b1001 -> grant order 3 then 0; ptr ends at 1.
4. en low while req=4'b1111 with two ops in flight -> no gnt, both responses still arrive, busy falls after drain; raising en resumes from the saved ptr.
5. Async reset pulse one cycle after a grant -> all outputs 0 immediately; no rsp_valid after release; first new grant goes to index 0.
6. With XARB_WDOG_EN: force dp_valid=1 with no op issued -> err=1 and stays 1. Suppress dp_valid for an in-flight op -> err=1 and rsp_valid pulses with rsp_y=0. Without the macro, err stays 0 in both cases.

Source files
------------

// File: rtl/xor_unit_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared XOR datapath.
// master = arbiter side, slave = requesters/datapath side.
interface xor_unit_arbiter_if #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 4
);
  logic           en;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic           dp_start;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic [W-1:0]   dp_y;
  logic           dp_valid;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           busy;
  logic           err;

  modport master (
    input  en, req, a_in, b_in, dp_y, dp_valid,
    output gnt, dp_start, dp_a, dp_b, rsp_valid, rsp_y, busy, err
  );

  modport slave (
    output en, req, a_in, b_in, dp_y, dp_valid,
    input  gnt, dp_start, dp_a, dp_b, rsp_valid, rsp_y, busy, err
  );
endinterface

// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one LAT-cycle XOR datapath between N requesters.
// Optional XARB_WDOG_EN: sticky err on dp_valid / tag mismatch, missing results answered with 0.
module xor_unit_arbiter #(
  parameter int unsigned W   = 16,
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  xor_unit_arbiter_if.master  bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]          outstanding;
  logic [N-1:0]          elig;
  logic [N-1:0]          rot;
  logic [N-1:0]          win_oh;
  logic [N-1:0]          rsp_oh;
  logic [N-1:0]          gnt_q;
  logic [N-1:0]          rsp_valid_q;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_nxt;
  logic [PW-1:0]         win;
  int unsigned           win_i;
  logic                  found;
  logic [W-1:0]          sel_a;
  logic [W-1:0]          sel_b;
  logic [W-1:0]          dp_a_q;
  logic [W-1:0]          dp_b_q;
  logic [W-1:0]          rsp_y_q;
  logic [W-1:0]          rsp_data;
  logic                  dp_start_q;
  logic                  err_q;
  logic                  fin_v;
  logic                  rsp_fire;
  logic                  mismatch;
  logic [LAT:0]          tag_v;
  logic [LAT:0][PW-1:0]  tag_id;

  // Rotate eligibility so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    elig    = bus.req & ~outstanding & {N{bus.en}};
    rot     = N'({elig, elig} >> ptr);
    found   = 1'b0;
    win_i   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win_i = k + 32'(ptr);
        if (win_i >= N) win_i = win_i - N;
      end
    end
    win     = PW'(win_i);
    win_oh  = found ? (N'(1) << win_i) : '0;
    ptr_nxt = (win_i + 1 >= N) ? '0 : PW'(win_i + 1);
    sel_a   = '0;
    sel_b   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        sel_a = bus.a_in[i*W +: W];
        sel_b = bus.b_in[i*W +: W];
      end
    end
  end

  always_comb begin
    fin_v  = tag_v[LAT];
    rsp_oh = N'(1) << tag_id[LAT];
`ifdef XARB_WDOG_EN
    rsp_fire = fin_v;
    rsp_data = bus.dp_valid ? bus.dp_y : '0;
    mismatch = fin_v ^ bus.dp_valid;
`else
    rsp_fire = fin_v & bus.dp_valid;
    rsp_data = bus.dp_y;
    mismatch = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      dp_start_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      ptr         <= '0;
      tag_v       <= '0;
      tag_id      <= '0;
      outstanding <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      gnt_q      <= win_oh;
      dp_start_q <= found;
      if (found) begin
        dp_a_q <= sel_a;
        dp_b_q <= sel_b;
        ptr    <= ptr_nxt;
      end
      tag_v  <= {tag_v[LAT-1:0], found};
      tag_id <= {tag_id[LAT-1:0], win};
      // Clear and set never hit the same id in one edge: an outstanding id is not eligible.
      outstanding <= (outstanding & ~(rsp_fire ? rsp_oh : '0)) | win_oh;
      rsp_valid_q <= rsp_fire ? rsp_oh : '0;
      if (rsp_fire) rsp_y_q <= rsp_data;
      err_q <= err_q | mismatch;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.dp_start  = dp_start_q;
  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.busy      = dp_start_q | (|tag_v) | (|outstanding);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Self-checking bench for xor_unit_arbiter: directed table, corner sequences and random traffic
// against a queue-based reference model; honours XARB_WDOG_EN if defined.
module tb_xor_unit_arbiter;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sup_dv = 1'b0;
  logic frc_dv = 1'b0;

  xor_unit_arbiter_if #(.W(W), .N(N)) bus ();

  xor_unit_arbiter #(.W(W), .N(N), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the 2-cycle XOR datapath, with fault injection hooks.
  logic         p_v0, p_v1;
  logic [W-1:0] p_y0, p_y1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v0 <= 1'b0; p_v1 <= 1'b0; p_y0 <= '0; p_y1 <= '0;
    end else begin
      p_v0 <= bus.dp_start;
      p_y0 <= bus.dp_a ^ bus.dp_b;
      p_v1 <= p_v0;
      p_y1 <= p_y0;
    end
  end
  assign bus.dp_valid = (p_v1 & ~sup_dv) | frc_dv;
  assign bus.dp_y     = p_v1 ? p_y1 : (frc_dv ? 16'hDEAD : '0);

  typedef struct { int id; logic [W-1:0] y; int age; } op_t;
  typedef struct {
    bit rst; bit en; logic [N-1:0] req;
    logic [N-1:0] gnt; logic [N-1:0] rsp; logic [W-1:0] y; bit busy;
  } vec_t;

  op_t          q[$];
  vec_t         tbl[$];
  int           m_ptr;
  logic [N-1:0] m_out;
  logic [N-1:0] e_gnt, e_rsp;
  logic         e_start, e_busy, e_err;
  logic [W-1:0] e_a, e_b, e_y;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic model_reset();
    q.delete();
    m_ptr = 0; m_out = '0;
    e_gnt = '0; e_rsp = '0; e_start = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    e_a = '0; e_b = '0; e_y = '0;
  endtask

  task automatic compare(input string nm);
    vectors++;
    if ({bus.gnt, bus.dp_start, bus.dp_a, bus.dp_b, bus.rsp_valid, bus.rsp_y, bus.busy, bus.err} !==
        {e_gnt, e_start, e_a, e_b, e_rsp, e_y, e_busy, e_err}) begin
      miscompares++;
      $display("FAIL %s t=%0t got/exp gnt %b/%b start %b/%b a %h/%h b %h/%h rsp %b/%b y %h/%h busy %b/%b err %b/%b",
               nm, $time, bus.gnt, e_gnt, bus.dp_start, e_start, bus.dp_a, e_a, bus.dp_b, e_b,
               bus.rsp_valid, e_rsp, bus.rsp_y, e_y, bus.busy, e_busy, bus.err, e_err);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // One clock of the reference model: predict post-edge outputs, then compare.
  task automatic step(input string nm);
    int           fidx, w, idx;
    bit           has_final, dv;
    logic [N-1:0] elig;
    fidx = -1;
    for (int i = 0; i < q.size(); i++) if (q[i].age == LAT) fidx = i;
    has_final = (fidx >= 0);
    dv = (has_final && !sup_dv) || frc_dv;
    elig = bus.req & ~m_out;
    w = -1;
    if (bus.en) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && ((elig >> idx) & N'(1)) != '0) w = idx;
      end
    end
    e_rsp = '0;
    if (has_final) begin
`ifdef XARB_WDOG_EN
      e_rsp = N'(1) << q[fidx].id;
      e_y   = dv ? q[fidx].y : '0;
      m_out = m_out & ~(N'(1) << q[fidx].id);
`else
      if (dv) begin
        e_rsp = N'(1) << q[fidx].id;
        e_y   = q[fidx].y;
        m_out = m_out & ~(N'(1) << q[fidx].id);
      end
`endif
      q.delete(fidx);
    end
`ifdef XARB_WDOG_EN
    if (dv != has_final) e_err = 1'b1;
`endif
    for (int i = 0; i < q.size(); i++) q[i].age++;
    e_gnt = '0; e_start = 1'b0;
    if (w >= 0) begin
      e_gnt   = N'(1) << w;
      e_start = 1'b1;
      e_a     = W'(bus.a_in >> (w*W));
      e_b     = W'(bus.b_in >> (w*W));
      m_ptr   = (w + 1) % N;
      m_out   = m_out | (N'(1) << w);
      q.push_back('{w, e_a ^ e_b, 0});
    end
    e_busy = (q.size() != 0) || (m_out != '0);
    @(posedge clk); #1;
    compare(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 compare("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_err;
    int   seen;
    bus.en = 1'b0; bus.req = '0; bus.a_in = '0; bus.b_in = '0;
    model_reset();

    // Directed table: single request, wrap from ptr 3, all four held from reset.
    tbl.push_back('{1, 1, 4'b0100, 4'b0100, 4'b0000, 16'h0000, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0100, 16'h0FF0, 0});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0FF0, 0});
    tbl.push_back('{0, 1, 4'b1001, 4'b1000, 4'b0000, 16'h0FF0, 1});
    tbl.push_back('{0, 1, 4'b1001, 4'b0001, 4'b0000, 16'h0FF0, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h0FF0, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b1000, 16'h4040, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0001, 16'h1010, 0});
    tbl.push_back('{0, 1, 4'b0011, 4'b0010, 4'b0000, 16'h1010, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h1010, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0000, 16'h1010, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0010, 16'h2020, 0});
    tbl.push_back('{1, 1, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 1});
    tbl.push_back('{0, 1, 4'b1111, 4'b0010, 4'b0000, 16'h0000, 1});
    tbl.push_back('{0, 1, 4'b1111, 4'b0100, 4'b0000, 16'h0000, 1});
    tbl.push_back('{0, 1, 4'b1111, 4'b1000, 4'b0001, 16'h1010, 1});
    tbl.push_back('{0, 1, 4'b1111, 4'b0001, 4'b0010, 16'h2020, 1});
    tbl.push_back('{0, 1, 4'b1111, 4'b0010, 4'b0100, 16'h0FF0, 1});
    tbl.push_back('{0, 1, 4'b1111, 4'b0100, 4'b1000, 16'h4040, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0001, 16'h1010, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0010, 16'h2020, 1});
    tbl.push_back('{0, 1, 4'b0000, 4'b0000, 4'b0100, 16'h0FF0, 0});

    bus.a_in = {16'h4444, 16'h00FF, 16'h2222, 16'h1111};
    bus.b_in = {16'h0404, 16'h0F0F, 16'h0202, 16'h0101};
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      bus.en  = tbl[i].en;
      bus.req = tbl[i].req;
      step("tbl_model");
      check_val($sformatf("tbl%0d_gnt", i),  32'(bus.gnt),       32'(tbl[i].gnt));
      check_val($sformatf("tbl%0d_rsp", i),  32'(bus.rsp_valid), 32'(tbl[i].rsp));
      check_val($sformatf("tbl%0d_y", i),    32'(bus.rsp_y),     32'(tbl[i].y));
      check_val($sformatf("tbl%0d_busy", i), 32'(bus.busy),      32'(tbl[i].busy));
    end

    // en low with two ops in flight: they drain, then arbitration resumes at saved ptr.
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0011;
    step("en_issue0");
    step("en_issue1");
    bus.en = 1'b0; bus.req = 4'b1111;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step("en_low");
      if (bus.rsp_valid != '0) seen++;
      check_val("en_low_gnt", 32'(bus.gnt), 32'h0);
    end
    check_val("en_low_rsp_count", 32'(seen), 32'd2);
    check_val("en_low_busy", 32'(bus.busy), 32'h0);
    bus.en = 1'b1;
    step("en_resume");
    check_val("en_resume_gnt", 32'(bus.gnt), 32'h4);

    // Async reset one cycle after a grant discards the op.
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0001;
    step("ar_issue");
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare("ar_async");
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = '0;
    for (int i = 0; i < 5; i++) step("ar_quiet");
    bus.req = 4'b1111;
    step("ar_first");
    check_val("ar_first_gnt", 32'(bus.gnt), 32'h1);

    // Spurious and missing dp_valid.
`ifdef XARB_WDOG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    bus.req = '0;
    frc_dv = 1'b1;
    step("wd_spur");
    frc_dv = 1'b0;
    step("wd_after0");
    step("wd_after1");
    check_val("wd_spur_err", 32'(bus.err), 32'(exp_err));
    bus.req = 4'b0010; bus.b_in = {16'h0, 16'h0, 16'h00F0, 16'h0};
    step("wd_issue");
    bus.req = '0; sup_dv = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step("wd_miss");
      if (bus.rsp_valid == 4'b0010 && bus.rsp_y == '0) seen++;
    end
    sup_dv = 1'b0;
    check_val("wd_miss_rsp", 32'(seen), 32'(exp_err));
    check_val("wd_miss_err", 32'(bus.err), 32'(exp_err));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.en   = ($urandom_range(0, 7) != 0);
      bus.req  = N'($urandom());
      bus.a_in = {$urandom(), $urandom()};
      bus.b_in = {$urandom(), $urandom()};
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
